i2c_master_engine: RTL

Synthesizable byte-level I2C master that sits directly upstream of the `i2c_if` slave BFM on the shared `scl`/`sda` bus. It executes START, STOP, WRITE-byte and READ-byte commands from a valid/ready command port. It generates SCL from a clock divider, drives the open-drain SDA/SCL enables, and returns sampled ACK or read data on a one-cycle response port.

---
 rtl/i2c_master_engine.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/i2c_master_engine.sv
// Byte-level I2C master: START / STOP / WRITE / READ commands over open-drain SCL/SDA.
// Define I2C_MASTER_STRETCH_EN to let a slave stretch SCL during high quarters.
module i2c_master_engine #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  input  logic [7:0] cmd_data_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       rsp_ack_o,
  output logic       rsp_err_o,
  output logic       busy_o,
  output logic       scl_o,
  output logic       sda_o,
  input  logic       scl_i,
  input  logic       sda_i
);

  typedef enum logic [2:0] {IDLE, START, RSTART_PRE, BIT, STOP, RESP} state_t;

  localparam logic [15:0] QLAST = 16'(CLK_DIV - 1);

  state_t      state, state_n;
  logic [15:0] qcnt, qcnt_n;
  logic [1:0]  qidx, qidx_n;
  logic [3:0]  bitn, bitn_n;
  logic [7:0]  tx, tx_n, rx, rx_n;
  logic        rd, rd_n, ackb, ackb_n;
  logic        scl_n, sda_n, slot_bit;
  logic        accept, legal, hold, qend, sample;

`ifdef I2C_MASTER_STRETCH_EN
  // A released SCL that still reads low is a slave stretching the clock.
  assign hold = scl_o && !scl_i;
`else
  logic scl_unused;
  assign scl_unused = scl_i;
  assign hold = 1'b0;
`endif

  assign accept = cmd_valid_i && cmd_ready_o;
  assign legal  = (cmd_i == 2'b00) || busy_o;
  assign qend   = (qcnt == QLAST) && !hold;
  assign sample = (state == BIT) && (qidx == 2'd1) && qend;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, RESP: begin
        state_n = IDLE;
        if (accept) begin
          if (!legal) state_n = RESP;
          else begin
            case (cmd_i)
              2'b00:   state_n = busy_o ? RSTART_PRE : START;
              2'b01:   state_n = STOP;
              default: state_n = BIT;
            endcase
          end
        end
      end
      START:      if (qend && qidx == 2'd2) state_n = RESP;
      RSTART_PRE: if (qend && qidx == 2'd1) state_n = START;
      BIT:        if (qend && qidx == 2'd3 && bitn == 4'd8) state_n = RESP;
      STOP:       if (qend && qidx == 2'd3) state_n = RESP;
      default:    state_n = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = (state == IDLE) || (state == RESP);
    rsp_valid_o = (state == RESP);
  end

  // Quarter/slot counters and shift registers.
  always_comb begin
    qcnt_n = qcnt;
    qidx_n = qidx;
    bitn_n = bitn;
    tx_n   = tx;
    rx_n   = rx;
    rd_n   = rd;
    ackb_n = ackb;
    if (accept) begin
      qcnt_n = '0;
      qidx_n = '0;
      bitn_n = '0;
      tx_n   = cmd_data_i;
      rd_n   = cmd_i[0];
      ackb_n = cmd_data_i[0];
    end else if (state != IDLE && state != RESP && !hold) begin
      if (qcnt == QLAST) begin
        qcnt_n = '0;
        qidx_n = qidx + 2'd1;
        if (state == RSTART_PRE && qidx == 2'd1) qidx_n = 2'd0;
        if (state == BIT && qidx == 2'd3) bitn_n = bitn + 4'd1;
      end else begin
        qcnt_n = qcnt + 16'd1;
      end
      if (sample && bitn < 4'd8) rx_n = {rx[6:0], sda_i};
    end
  end

  // Bus levels for the quarter being entered; IDLE/RESP keep the last levels.
  always_comb begin
    slot_bit = (bitn_n < 4'd8) ? (rd_n | tx_n[3'd7 - bitn_n[2:0]]) : (!rd_n | ackb_n);
    scl_n = scl_o;
    sda_n = sda_o;
    case (state_n)
      START: begin
        scl_n = (qidx_n != 2'd2);
        sda_n = (qidx_n == 2'd0);
      end
      RSTART_PRE: begin
        scl_n = (qidx_n == 2'd1);
        sda_n = 1'b1;
      end
      BIT: begin
        scl_n = (qidx_n == 2'd1) || (qidx_n == 2'd2);
        sda_n = slot_bit;
      end
      STOP: begin
        scl_n = (qidx_n != 2'd0);
        sda_n = qidx_n[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      qcnt       <= '0;
      qidx       <= '0;
      bitn       <= '0;
      tx         <= '0;
      rx         <= '0;
      rd         <= 1'b0;
      ackb       <= 1'b1;
      scl_o      <= 1'b1;
      sda_o      <= 1'b1;
      busy_o     <= 1'b0;
      rsp_data_o <= '0;
      rsp_ack_o  <= 1'b0;
      rsp_err_o  <= 1'b0;
    end else begin
      qcnt  <= qcnt_n;
      qidx  <= qidx_n;
      bitn  <= bitn_n;
      tx    <= tx_n;
      rx    <= rx_n;
      rd    <= rd_n;
      ackb  <= ackb_n;
      scl_o <= scl_n;
      sda_o <= sda_n;
      if (accept) rsp_err_o <= !legal;
      if (sample && bitn == 4'd8 && !rd) rsp_ack_o <= sda_i;
      if (state_n == RESP) begin
        if (state == START) busy_o <= 1'b1;
        if (state == STOP)  busy_o <= 1'b0;
        if (state == BIT && rd) rsp_data_o <= rx;
      end
    end
  end

endmodule
